// File: rtl/photodiode_pixel_array_if.sv
// Bus between the optical stimulus and the photodiode pixel array: frame control,
// per-channel photocurrent in, live/held pixel voltages and status out.
interface photodiode_pixel_array_if #(
  parameter int N_CH = 4
);
  logic            start;
  logic            cont;
  real             iph  [N_CH];
  real             vpix [N_CH];
  real             vout [N_CH];
  logic [N_CH-1:0] sat;
  logic            valid;
  logic            busy;
  logic [15:0]     frame_cnt;

  modport master (
    output start, cont, iph,
    input  vpix, vout, sat, valid, busy, frame_cnt
  );

  modport slave (
    input  start, cont, iph,
    output vpix, vout, sat, valid, busy, frame_cnt
  );
endinterface

// File: rtl/photodiode_pixel_array.sv
// Real-number model of an N-channel integrating photodiode array with a
// reset/integrate/sample frame sequencer, saturation clamp and sticky flags.
module photodiode_pixel_array #(
  parameter int  N_CH      = 4,
  parameter int  RST_CYC   = 4,
  parameter int  INT_CYC   = 16,
  parameter real T_CLK_NS  = 2.0,
  parameter real C_PD_FF   = 100.0,
  parameter real I_DARK_UA = 0.0,
  parameter real V_RST     = 1.8,
  parameter real V_SAT     = 0.2
) (
  input logic                    clk,
  input logic                    rst,
  photodiode_pixel_array_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RESET, INTEGRATE, SAMPLE} state_t;

  localparam int  CNT_MAX = (RST_CYC > INT_CYC) ? RST_CYC : INT_CYC;
  localparam int  CNT_W   = $clog2(CNT_MAX + 1);
  localparam real K_STEP  = T_CLK_NS / C_PD_FF;  // uA*ns/fF -> V

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  real             vpix_q [N_CH];
  real             vpix_nxt [N_CH];
  real             vout_q [N_CH];
  real             vout_nxt [N_CH];
  logic [N_CH-1:0] sat_int, sat_int_nxt, sat_q, sat_nxt;
  logic            valid_q, valid_nxt;
  logic [15:0]     fcnt, fcnt_nxt;

  // Unclamped node voltage after one integration step; negative photocurrent is ignored.
  function automatic real integrate_step(input real v, input real i);
    real i_eff;
    i_eff = ((i > 0.0) ? i : 0.0) + I_DARK_UA;
    return v - i_eff * K_STEP;
  endfunction

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    vpix_nxt    = vpix_q;
    vout_nxt    = vout_q;
    sat_int_nxt = sat_int;
    sat_nxt     = sat_q;
    valid_nxt   = 1'b0;
    fcnt_nxt    = fcnt;

    case (state)
      IDLE: begin
        for (int k = 0; k < N_CH; k++) vpix_nxt[k] = V_RST;
        if (bus.start) begin
          state_nxt = RESET;
          cnt_nxt   = '0;
        end
      end
      RESET: begin
        for (int k = 0; k < N_CH; k++) vpix_nxt[k] = V_RST;
        sat_int_nxt = '0;
        if (cnt == CNT_W'(RST_CYC - 1)) begin
          state_nxt = INTEGRATE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      INTEGRATE: begin
        for (int k = 0; k < N_CH; k++) begin
          if (integrate_step(vpix_q[k], bus.iph[k]) < V_SAT) begin
            vpix_nxt[k]    = V_SAT;
            sat_int_nxt[k] = 1'b1;
          end else begin
            vpix_nxt[k] = integrate_step(vpix_q[k], bus.iph[k]);
          end
        end
        if (cnt == CNT_W'(INT_CYC - 1)) begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      SAMPLE: begin
        vout_nxt  = vpix_q;
        sat_nxt   = sat_int;
        valid_nxt = 1'b1;
        fcnt_nxt  = fcnt + 16'd1;
        for (int k = 0; k < N_CH; k++) vpix_nxt[k] = V_RST;
        state_nxt = bus.cont ? RESET : IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sat_int <= '0;
      sat_q   <= '0;
      valid_q <= 1'b0;
      fcnt    <= '0;
      for (int k = 0; k < N_CH; k++) begin
        vpix_q[k] <= V_RST;
        vout_q[k] <= V_RST;
      end
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sat_int <= sat_int_nxt;
      sat_q   <= sat_nxt;
      valid_q <= valid_nxt;
      fcnt    <= fcnt_nxt;
      vpix_q  <= vpix_nxt;
      vout_q  <= vout_nxt;
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      bus.vpix[k] = vpix_q[k];
      bus.vout[k] = vout_q[k];
    end
    bus.sat       = sat_q;
    bus.valid     = valid_q;
    bus.busy      = (state != IDLE);
    bus.frame_cnt = fcnt;
  end

endmodule

// File: tb/tb_photodiode_pixel_array.sv
// Scoreboard bench: stimulus queues expected frames, negedge monitors compare on valid.
module tb_photodiode_pixel_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchecks = 0;
  int   nerr = 0;
  int   seen_a = 0;
  int   seen_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  photodiode_pixel_array_if #(.N_CH(4)) bus_a ();
  photodiode_pixel_array_if #(.N_CH(4)) bus_b ();

  photodiode_pixel_array dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  photodiode_pixel_array #(.I_DARK_UA(0.1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    real         v [4];
    logic [3:0]  sat;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t q_a [$];
  exp_t q_b [$];

  function automatic exp_t mk(input real v0, input real v1, input real v2, input real v3,
                              input logic [3:0] s, input logic [15:0] c, input int cy);
    exp_t e;
    e.v[0] = v0; e.v[1] = v1; e.v[2] = v2; e.v[3] = v3;
    e.sat = s; e.cnt = c; e.cyc = cy;
    return e;
  endfunction

  task automatic check_real(input string name, input real got, input real exp);
    nchecks++;
    if (got - exp > 1.0e-6 || exp - got > 1.0e-6) begin
      nerr++;
      $display("FAIL %s: got %f expected %f", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input longint got, input longint exp);
    nchecks++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic compare_frame(input string tag, input exp_t e, input real vo [4],
                               input logic [3:0] s, input logic [15:0] fc);
    for (int k = 0; k < 4; k++) check_real($sformatf("%s_vout%0d", tag, k), vo[k], e.v[k]);
    check_int({tag, "_sat"}, s, e.sat);
    check_int({tag, "_frame_cnt"}, fc, e.cnt);
    check_int({tag, "_valid_cycle"}, cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_a.valid) begin
      if (q_a.size() == 0) begin
        nchecks++; nerr++;
        $display("FAIL unexpected_valid_a: got valid at cycle %0d expected none", cyc);
      end else begin
        e = q_a.pop_front();
        compare_frame("a", e, bus_a.vout, bus_a.sat, bus_a.frame_cnt);
      end
      seen_a++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_b.valid) begin
      if (q_b.size() == 0) begin
        nchecks++; nerr++;
        $display("FAIL unexpected_valid_b: got valid at cycle %0d expected none", cyc);
      end else begin
        e = q_b.pop_front();
        compare_frame("b", e, bus_b.vout, bus_b.sat, bus_b.frame_cnt);
      end
      seen_b++;
    end
  end

  task automatic wait_seen_a(input int target);
    for (int i = 0; i < 200 && seen_a < target; i++) @(negedge clk);
    check_int("frame_arrival_a", seen_a, target);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_iph_a(input real i0, input real i1, input real i2, input real i3);
    bus_a.iph[0] = i0; bus_a.iph[1] = i1; bus_a.iph[2] = i2; bus_a.iph[3] = i3;
  endtask

  // Start pulse driven on a negedge; the next rising edge is the start edge E.
  task automatic pulse_start_a();
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end by cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus_a.start = 1'b0; bus_a.cont = 1'b0;
    bus_b.start = 1'b0; bus_b.cont = 1'b0;
    set_iph_a(0.0, 0.0, 0.0, 0.0);
    for (int k = 0; k < 4; k++) bus_b.iph[k] = 0.0;

    // Reset state
    idle_cycles(3);
    check_int("rst_busy", bus_a.busy, 0);
    check_int("rst_valid", bus_a.valid, 0);
    check_int("rst_frame_cnt", bus_a.frame_cnt, 0);
    check_int("rst_sat", bus_a.sat, 0);
    check_real("rst_vout0", bus_a.vout[0], 1.8);
    check_real("rst_vpix3", bus_a.vpix[3], 1.8);
    rst = 1'b0;
    idle_cycles(2);

    // Frame 1: 1.0 uA everywhere, 0.02 V/step, 1.8 - 16*0.02 = 1.48
    set_iph_a(1.0, 1.0, 1.0, 1.0);
    q_a.push_back(mk(1.48, 1.48, 1.48, 1.48, 4'b0000, 16'd1, cyc + 22));
    pulse_start_a();
    check_int("busy_after_start", bus_a.busy, 1);
    idle_cycles(5);
    check_real("first_step_vpix0", bus_a.vpix[0], 1.78);
    wait_seen_a(1);
    idle_cycles(2);
    check_int("busy_low_after_single", bus_a.busy, 0);
    check_real("idle_vpix_reset", bus_a.vpix[2], 1.8);

    // Frame 2: channel 0 saturates after 8 steps of 0.2 V
    set_iph_a(10.0, 0.0, 0.0, 0.0);
    q_a.push_back(mk(0.2, 1.8, 1.8, 1.8, 4'b0001, 16'd2, cyc + 22));
    pulse_start_a();
    idle_cycles(12);
    check_real("sat_vpix0_at8", bus_a.vpix[0], 0.2);
    check_real("sat_vpix1_flat", bus_a.vpix[1], 1.8);
    check_real("vout_held_midframe", bus_a.vout[0], 1.48);
    idle_cycles(8);
    check_real("sat_vpix0_clamped", bus_a.vpix[0], 0.2);
    wait_seen_a(2);
    idle_cycles(2);

    // Frames 3-5: continuous, 0.5 uA -> 1.64 V; stray start in frame 4, cont dropped in frame 5
    set_iph_a(0.5, 0.5, 0.5, 0.5);
    bus_a.cont = 1'b1;
    q_a.push_back(mk(1.64, 1.64, 1.64, 1.64, 4'b0000, 16'd3, cyc + 22));
    q_a.push_back(mk(1.64, 1.64, 1.64, 1.64, 4'b0000, 16'd4, cyc + 43));
    q_a.push_back(mk(1.64, 1.64, 1.64, 1.64, 4'b0000, 16'd5, cyc + 64));
    pulse_start_a();
    wait_seen_a(3);
    idle_cycles(10);
    pulse_start_a();
    wait_seen_a(4);
    idle_cycles(5);
    bus_a.cont = 1'b0;
    wait_seen_a(5);
    idle_cycles(25);
    check_int("busy_low_after_cont", bus_a.busy, 0);
    check_int("cont_frame_cnt", bus_a.frame_cnt, 5);

    // Frame 6: start during INTEGRATE is ignored
    set_iph_a(1.0, 1.0, 1.0, 1.0);
    q_a.push_back(mk(1.48, 1.48, 1.48, 1.48, 4'b0000, 16'd6, cyc + 22));
    pulse_start_a();
    idle_cycles(9);
    pulse_start_a();
    wait_seen_a(6);
    idle_cycles(25);
    check_int("ignored_start_busy", bus_a.busy, 0);
    check_int("ignored_start_frame_cnt", bus_a.frame_cnt, 6);

    // Async reset mid-INTEGRATE: immediate return to reset values, no valid
    set_iph_a(2.0, 2.0, 2.0, 2.0);
    pulse_start_a();
    idle_cycles(10);
    rst = 1'b1;
    #1;
    check_int("midrst_busy", bus_a.busy, 0);
    check_int("midrst_valid", bus_a.valid, 0);
    check_int("midrst_frame_cnt", bus_a.frame_cnt, 0);
    check_real("midrst_vpix0", bus_a.vpix[0], 1.8);
    check_real("midrst_vout0", bus_a.vout[0], 1.8);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(25);
    check_int("midrst_no_frame", seen_a, 6);

    // Fresh frame after reset
    set_iph_a(1.0, 1.0, 1.0, 1.0);
    q_a.push_back(mk(1.48, 1.48, 1.48, 1.48, 4'b0000, 16'd1, cyc + 22));
    pulse_start_a();
    wait_seen_a(7);
    idle_cycles(2);

    // Dark-current instance: negative iph -> dark only, 0.002 V/step
    bus_b.iph[0] = 0.0; bus_b.iph[1] = -1.0; bus_b.iph[2] = 0.5; bus_b.iph[3] = 0.0;
    q_b.push_back(mk(1.768, 1.768, 1.608, 1.768, 4'b0000, 16'd1, cyc + 22));
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    for (int i = 0; i < 200 && seen_b < 1; i++) @(negedge clk);
    check_int("frame_arrival_b", seen_b, 1);
    idle_cycles(3);

    check_int("queue_a_drained", q_a.size(), 0);
    check_int("queue_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/photodiode_pixel_array.md
# photodiode_pixel_array

Parametrised real-number model (RNM) of an N-channel integrating photodiode pixel array. It generalises the single-channel photodiode model to per-channel photocurrent inputs, a reset/integrate/sample frame sequencer, saturation clamping with flags, and single-shot or continuous frame modes. It sits between the optical stimulus (testbench or scene model) and the downstream readout/ADC models. Sampled voltages are held stable between frames.

## Interface
- N_CH, 4, number of pixel channels
- RST_CYC, 4, clock cycles spent in RESET per frame (≥1)
- INT_CYC, 16, clock cycles of integration per frame (≥1)
- T_CLK_NS, 2.0, clock period in ns used for integration arithmetic
- C_PD_FF, 100.0, photodiode node capacitance in fF
- I_DARK_UA, 0.0, dark current in µA added to every channel
- V_RST, 1.8, pixel reset voltage in V
- V_SAT, 0.2, lower clamp (saturation) voltage in V

- clk  input  1  sampling clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a frame; sampled only in IDLE
- cont  input  1  continuous mode: 1 = back-to-back frames, 0 = single frame
- iph  input  real[N_CH]  per-channel photocurrent in µA
- vpix  output  real[N_CH]  live integration node voltage in V
- vout  output  real[N_CH]  sampled and held pixel voltage in V
- sat  output  [N_CH]  per-channel saturation flag for the last sampled frame
- valid  output  1  one-cycle pulse when vout/sat update
- busy  output  1  high in any state other than IDLE
- frame_cnt  output  16  completed-frame counter

## Operation
- States: IDLE, RESET, INTEGRATE, SAMPLE.
- IDLE: vpix held at V_RST. A start=1 at an edge moves the state to RESET.
- RESET: vpix = V_RST, internal sat_int cleared. The state holds for RST_CYC edges, then moves to INTEGRATE.
- INTEGRATE: on each of INT_CYC edges, for each channel: vpix[k] -= (max(iph[k],0) + I_DARK_UA) * T_CLK_NS / C_PD_FF. Units µA·ns/fF yield volts.
  - Negative iph is treated as 0.
  - If the result is below V_SAT, vpix[k] = V_SAT and sat_int[k] = 1. sat_int is sticky until the next RESET.
  - After INT_CYC updates the state moves to SAMPLE.
- SAMPLE: vpix is frozen (no update). At the next edge:
  - vout <= vpix and sat <= sat_int.
  - valid <= 1 for exactly one cycle.
  - frame_cnt increments, wrapping 0xFFFF→0.
  - The state then moves to RESET if cont=1, else IDLE.
- start asserted while busy is ignored.
- cont is sampled only at the SAMPLE exit edge. Deasserting cont mid-frame completes the current frame, then the block returns to IDLE.
- iph is sampled at each INTEGRATE edge, so changes take effect on the next edge.

## Timing
- Reset values: state=IDLE, vpix[*]=V_RST, vout[*]=V_RST, sat=0, valid=0, busy=0, frame_cnt=0.
- rst acts immediately (asynchronous), including mid-frame: no partial frame is sampled and no valid is produced.
- Latency: start seen at edge E → valid high after edge E+RST_CYC+INT_CYC+1. With defaults this is E+21.
- busy rises after edge E and falls after the SAMPLE exit edge when cont=0.
- Continuous-mode frame period: RST_CYC+INT_CYC+1 cycles (21 with defaults). valid pulses once per period.
- vout and sat change only on the valid edge; they are stable otherwise.

## Test plan
- Single frame, defaults, all iph=1.0 µA, start pulse.
  - Per-cycle step 0.02 V.
  - valid exactly 21 cycles after start; vout=1.48 V on all channels; sat=0; frame_cnt=1; busy low afterwards.
- Saturation: iph[0]=10.0 µA, others 0.
  - vpix[0] reaches 0.2 V after 8 INTEGRATE edges and stays clamped.
  - At valid: vout[0]=0.2, sat[0]=1; vout[1..3]=1.8, sat[1..3]=0.
- Continuous mode: cont=1, iph=0.5 µA, run 3 frames.
  - valid pulses 21 cycles apart; vout=1.64 V each frame; frame_cnt 1,2,3.
  - Dropping cont during frame 3 leaves IDLE after frame 3.
- start asserted during INTEGRATE is ignored: no extra frame, frame_cnt unchanged, frame period unchanged.
- Assert rst mid-INTEGRATE:
  - Outputs return to reset values immediately; no valid pulse.
  - A subsequent start produces a correct fresh frame.
- Negative and dark current: iph[1]=-1.0 µA with I_DARK_UA=0.1.
  - Channel 1 integrates dark current only: vout[1]=1.8-16*0.002=1.768 V.
